// File: rtl/game_controller_pkg.sv
// Shared Pong match definitions: state encodings, widths, serve directions and
// the saturating score increment used by the match sequencer.
package game_controller_pkg;

  localparam int SCORE_W = 4;
  localparam int FRAME_W = 8;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [FRAME_W-1:0] frame_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_POINT     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  // A match ends on reaching the limit, so holding there is only a safety net.
  function automatic score_t sat_inc(input score_t score, input score_t limit);
    return (score >= limit) ? score : score + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_controller_frame_timer.sv
// 8-bit frame counter with clear (priority over tick) and a terminal pulse that
// fires on the tick that brings the count up to target.
module frame_timer
  import game_controller_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   tick,
  input  frame_t target,
  output logic   hit
);

  frame_t count;

  assign hit = tick && ((count + FRAME_W'(1)) == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + FRAME_W'(1);
    end
  end

endmodule

// File: rtl/game_controller.sv
// Pong match sequencer: owns both scores, releases and freezes the ball, and
// sequences attract -> serve -> play -> point pause -> ... -> game over.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 90,
  parameter int BLINK_FRAMES = 30
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_frame_tick,
  input  logic         i_start,
  input  logic         i_point1,
  input  logic         i_point2,
  output logic [3:0]   o_score1,
  output logic [3:0]   o_score2,
  output logic         o_ball_run,
  output logic         o_serve_dir,
  output logic         o_game_over,
  output logic         o_winner,
  output logic         o_score_blink
);

  localparam score_t WIN = SCORE_W'(WIN_SCORE);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       start_prev;
  logic       start_edge;
  frame_t     phase_target;
  logic       phase_clear;
  logic       phase_hit;
  logic       blink_clear;
  logic       blink_hit;
  logic       win_reached;
  logic       match_start;

  assign win_reached = (o_score1 == WIN) || (o_score2 == WIN);
  assign match_start = start_edge && ((state == ST_IDLE) || (state == ST_GAME_OVER));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start_edge) state_next = ST_SERVE;
      ST_SERVE:     if (phase_hit) state_next = ST_PLAY;
      ST_PLAY:      if (i_point1 || i_point2) state_next = ST_POINT;
      ST_POINT:     if (phase_hit) state_next = win_reached ? ST_GAME_OVER : ST_SERVE;
      ST_GAME_OVER: if (start_edge) state_next = ST_SERVE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Entering a timed state clears its counter, so a coincident tick is not counted.
  assign phase_target = (state == ST_SERVE) ? FRAME_W'(SERVE_FRAMES) : FRAME_W'(PAUSE_FRAMES);
  assign phase_clear  = (state_next != state) || !((state == ST_SERVE) || (state == ST_POINT));
  assign blink_clear  = (state != ST_GAME_OVER) || (state_next != ST_GAME_OVER) || blink_hit;

  frame_timer u_phase_timer (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clear  (phase_clear),
    .tick   (i_frame_tick),
    .target (phase_target),
    .hit    (phase_hit)
  );

  frame_timer u_blink_timer (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clear  (blink_clear),
    .tick   (i_frame_tick),
    .target (FRAME_W'(BLINK_FRAMES)),
    .hit    (blink_hit)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      start_prev    <= 1'b0;
      start_edge    <= 1'b0;
      o_score1      <= '0;
      o_score2      <= '0;
      o_ball_run    <= 1'b0;
      o_serve_dir   <= SERVE_LEFT;
      o_game_over   <= 1'b0;
      o_winner      <= 1'b0;
      o_score_blink <= 1'b1;
    end else begin
      state       <= state_next;
      start_prev  <= i_start;
      start_edge  <= i_start & ~start_prev;
      o_ball_run  <= (state_next == ST_PLAY);
      o_game_over <= (state_next == ST_GAME_OVER);

      if (match_start) begin
        o_score1    <= '0;
        o_score2    <= '0;
        o_serve_dir <= SERVE_LEFT;
      end else if ((state == ST_PLAY) && (i_point1 != i_point2)) begin
        // The scorer's opponent receives the next serve; a double pulse scores nobody.
        if (i_point1) begin
          o_score1    <= sat_inc(o_score1, WIN);
          o_serve_dir <= SERVE_RIGHT;
        end else begin
          o_score2    <= sat_inc(o_score2, WIN);
          o_serve_dir <= SERVE_LEFT;
        end
      end

      if ((state == ST_POINT) && (state_next == ST_GAME_OVER)) begin
        o_winner <= (o_score2 == WIN);
      end

      if (state_next != ST_GAME_OVER) begin
        o_score_blink <= 1'b1;
      end else if ((state == ST_GAME_OVER) && blink_hit) begin
        o_score_blink <= ~o_score_blink;
      end
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed vector table, reset corner cases and a
// randomized run against a phase/countdown reference model.
module tb_game_controller;

  localparam int WIN   = 2;
  localparam int SERVE = 3;
  localparam int PAUSE = 2;
  localparam int BLINK = 2;

  localparam logic [12:0] RESET_EXP = {4'd0, 4'd0, 5'b00001};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       ball_run;
  logic       serve_dir;
  logic       game_over;
  logic       winner;
  logic       score_blink;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_controller #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SERVE),
    .PAUSE_FRAMES (PAUSE),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_frame_tick  (tick),
    .i_start       (start),
    .i_point1      (p1),
    .i_point2      (p2),
    .o_score1      (score1),
    .o_score2      (score2),
    .o_ball_run    (ball_run),
    .o_serve_dir   (serve_dir),
    .o_game_over   (game_over),
    .o_winner      (winner),
    .o_score_blink (score_blink)
  );

  // Reference model: match phase plus frames-remaining countdowns.
  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mphase_t;
  mphase_t m_phase;
  int      m_s1, m_s2, m_left, m_bleft;
  bit      m_dir, m_win, m_blink, m_prev, m_edge;

  function void model_reset();
    m_phase = M_IDLE;
    m_s1 = 0; m_s2 = 0; m_left = 0; m_bleft = 0;
    m_dir = 0; m_win = 0; m_blink = 1; m_prev = 0; m_edge = 0;
  endfunction

  function void new_match();
    m_phase = M_SERVE;
    m_s1 = 0; m_s2 = 0; m_dir = 0; m_blink = 1; m_left = SERVE;
  endfunction

  function void model_step(input bit t, input bit s, input bit a, input bit b);
    bit se;
    se = m_edge;
    m_edge = s && !m_prev;
    m_prev = s;
    case (m_phase)
      M_IDLE: if (se) new_match();
      M_SERVE: if (t) begin
        m_left--;
        if (m_left == 0) m_phase = M_PLAY;
      end
      M_PLAY: if (a || b) begin
        if (a && !b) begin
          if (m_s1 < WIN) m_s1++;
          m_dir = 1;
        end else if (b && !a) begin
          if (m_s2 < WIN) m_s2++;
          m_dir = 0;
        end
        m_phase = M_POINT;
        m_left = PAUSE;
      end
      M_POINT: if (t) begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase = M_OVER;
            m_win = (m_s2 == WIN);
            m_blink = 1;
            m_bleft = BLINK;
          end else begin
            m_phase = M_SERVE;
            m_left = SERVE;
          end
        end
      end
      M_OVER: begin
        if (se) new_match();
        else if (t) begin
          m_bleft--;
          if (m_bleft == 0) begin
            m_blink = !m_blink;
            m_bleft = BLINK;
          end
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endfunction

  function automatic logic [12:0] model_outs();
    return {4'(m_s1), 4'(m_s2), m_phase == M_PLAY, m_dir, m_phase == M_OVER, m_win, m_blink};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {score1, score2, ball_run, serve_dir, game_over, winner, score_blink};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s @%0t: got s1=%0d s2=%0d run,dir,over,win,blink=%b ; expected s1=%0d s2=%0d run,dir,over,win,blink=%b",
                 name, $time, got[12:9], got[8:5], got[4:0], exp[12:9], exp[8:5], exp[4:0]);
    end
  endtask

  task automatic cycle(input bit t, input bit s, input bit a, input bit b);
    @(negedge clk);
    tick = t; start = s; p1 = a; p2 = b;
    @(posedge clk);
    model_step(t, s, a, b);
    #1;
  endtask

  typedef struct {
    bit t, s, a, b;
    logic [12:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit t, input bit s, input bit a, input bit b, input int s1, input int s2,
                     input bit run, input bit dir, input bit over, input bit win, input bit blink);
    vec_t v;
    v.t = t; v.s = s; v.a = a; v.b = b;
    v.exp = {4'(s1), 4'(s2), run, dir, over, win, blink};
    vecs.push_back(v);
  endtask

  initial begin
    bit lvl;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", dut_outs(), RESET_EXP);
    @(negedge clk);
    rst_n = 1'b1;

    // Attract mode holds with no start press.
    for (int f = 0; f < 1000; f++) begin
      cycle(1, 0, 0, 0);
      check("idle_hold", dut_outs(), RESET_EXP);
      cycle(0, 0, 0, 0);
    end

    // t s a b | s1 s2 run dir over win blink
    add(0,1,0,0, 0,0, 0,0,0,0,1);
    add(0,1,0,0, 0,0, 0,0,0,0,1);
    add(1,1,0,0, 0,0, 0,0,0,0,1);
    add(1,1,0,0, 0,0, 0,0,0,0,1);
    add(0,0,0,0, 0,0, 0,0,0,0,1);
    add(1,0,0,0, 0,0, 1,0,0,0,1);
    add(0,0,1,0, 1,0, 0,1,0,0,1);
    add(1,0,0,1, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 0,1,0,0,1);
    add(1,0,1,0, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 1,1,0,0,1);
    add(0,0,1,1, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 0,1,0,0,1);
    add(1,0,0,0, 1,0, 1,1,0,0,1);
    add(0,0,0,1, 1,1, 0,0,0,0,1);
    add(1,0,0,0, 1,1, 0,0,0,0,1);
    add(1,0,0,0, 1,1, 0,0,0,0,1);
    add(1,0,0,0, 1,1, 0,0,0,0,1);
    add(1,0,0,0, 1,1, 0,0,0,0,1);
    add(1,0,0,0, 1,1, 1,0,0,0,1);
    add(0,0,0,1, 1,2, 0,0,0,0,1);
    add(1,0,0,0, 1,2, 0,0,0,0,1);
    add(1,0,0,0, 1,2, 0,0,1,1,1);
    add(1,0,0,0, 1,2, 0,0,1,1,1);
    add(1,0,0,0, 1,2, 0,0,1,1,0);
    add(1,0,0,0, 1,2, 0,0,1,1,0);
    add(1,0,0,0, 1,2, 0,0,1,1,1);
    add(1,0,0,0, 1,2, 0,0,1,1,1);
    add(1,0,0,0, 1,2, 0,0,1,1,0);
    add(0,1,0,0, 1,2, 0,0,1,1,0);
    add(0,1,0,0, 0,0, 0,0,0,1,1);
    add(0,0,0,0, 0,0, 0,0,0,1,1);
    add(1,0,0,0, 0,0, 0,0,0,1,1);
    add(1,0,0,0, 0,0, 0,0,0,1,1);
    add(1,0,0,0, 0,0, 1,0,0,1,1);

    foreach (vecs[i]) begin
      cycle(vecs[i].t, vecs[i].s, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
    end

    // Reach POINT at 1/1, then drop reset mid-cycle.
    cycle(0, 0, 1, 0); check("to_1_0", dut_outs(), model_outs());
    for (int k = 0; k < PAUSE + SERVE; k++) begin
      cycle(1, 0, 0, 0); check("serve_again", dut_outs(), model_outs());
    end
    cycle(0, 0, 0, 1); check("to_1_1", dut_outs(), model_outs());
    cycle(1, 0, 0, 0); check("mid_point", dut_outs(), model_outs());
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_outs(), RESET_EXP);
    model_reset();
    @(posedge clk);
    #1 check("reset_held", dut_outs(), RESET_EXP);
    @(negedge clk);
    rst_n = 1'b1;

    lvl = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 15) == 0) lvl = !lvl;
      cycle($urandom_range(0, 3) == 0, lvl, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      check("random", dut_outs(), model_outs());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
